// File: rtl/pipe_scoreboard.sv
// Pipeline scoreboard: tracks register-writing instructions past decode,
// derives operand forwarding selects and the load-use stall for the
// instruction currently in decode, and keeps a saturating stall counter.
module pipe_scoreboard #(
    parameter int unsigned NSTAGES    = 3,
    parameter int unsigned REG_BITS   = 5,
    parameter int unsigned ALU_READY  = 1,
    parameter int unsigned LOAD_READY = 2,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic                id_regwrite,
    input  logic [REG_BITS-1:0] id_dest,
    input  logic                id_is_load,
    input  logic                flush,
    output logic                stall,
    output logic [SEL_W-1:0]    fwd_a,
    output logic [SEL_W-1:0]    fwd_b,
    output logic [NSTAGES-1:0]  slot_valid,
    output logic                retire_valid,
    output logic [REG_BITS-1:0] retire_dest,
    output logic [CNT_W-1:0]    stall_count
);

    // Index 0 is slot 1 (the slot right after decode).
    logic [NSTAGES-1:0]  slotValidQ;
    logic [NSTAGES-1:0]  slotLoadQ;
    logic [REG_BITS-1:0] slotDestQ [NSTAGES];
    logic [CNT_W-1:0]    stallCountQ;

    // Operand 0 is rs, operand 1 is rt.
    logic [REG_BITS-1:0] srcIdx   [2];
    logic                srcUse   [2];
    logic                srcFound [2];
    logic                srcWait  [2];
    logic [SEL_W-1:0]    srcSel   [2];
    logic                insertValid;

    // Present both source operands in a uniform form for the match loop.
    always_comb begin
        srcIdx[0] = id_rs;
        srcIdx[1] = id_rt;
        srcUse[0] = id_use_rs;
        srcUse[1] = id_use_rt;
    end

    // Youngest matching producer decides; an unready match blocks older slots.
    always_comb begin
        for (int unsigned op = 0; op < 2; op++) begin
            srcFound[op] = 1'b0;
            srcWait[op]  = 1'b0;
            srcSel[op]   = '0;
            for (int unsigned k = 0; k < NSTAGES; k++) begin
                if (!srcFound[op] && slotValidQ[k] && srcUse[op] &&
                    (srcIdx[op] != '0) && (slotDestQ[k] == srcIdx[op])) begin
                    srcFound[op] = 1'b1;
                    if ((k + 1) >= (slotLoadQ[k] ? LOAD_READY : ALU_READY)) begin
                        srcSel[op] = SEL_W'(k + 1);
                    end else begin
                        srcWait[op] = 1'b1;
                    end
                end
            end
        end
    end

    // Decode outputs and the slot-1 insertion decision.
    always_comb begin
        stall        = id_valid & ~flush & (srcWait[0] | srcWait[1]);
        fwd_a        = srcSel[0];
        fwd_b        = srcSel[1];
        insertValid  = id_valid & ~flush & ~stall & id_regwrite & (id_dest != '0);
        slot_valid   = slotValidQ;
        retire_valid = slotValidQ[NSTAGES-1];
        retire_dest  = slotValidQ[NSTAGES-1] ? slotDestQ[NSTAGES-1] : '0;
        stall_count  = stallCountQ;
    end

    // Advance the slot shift register; slot 1 takes decode or a bubble.
    always_ff @(posedge CLK) begin
        if (reset) begin
            slotValidQ <= '0;
            slotLoadQ  <= '0;
            for (int unsigned k = 0; k < NSTAGES; k++) begin
                slotDestQ[k] <= '0;
            end
        end else begin
            slotValidQ <= {slotValidQ[NSTAGES-2:0], insertValid};
            slotLoadQ  <= {slotLoadQ[NSTAGES-2:0], insertValid & id_is_load};
            for (int unsigned k = 1; k < NSTAGES; k++) begin
                slotDestQ[k] <= slotDestQ[k-1];
            end
            slotDestQ[0] <= insertValid ? id_dest : '0;
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge CLK) begin
        if (reset) begin
            stallCountQ <= '0;
        end else if (stall && (stallCountQ != '1)) begin
            stallCountQ <= stallCountQ + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed bench for pipe_scoreboard: a default-depth instance plus a deep
// instance (5 slots, load ready at 4, 2-bit counter). Retirements of the
// default instance are matched against a queue of accepted writers.
module tb_pipe_scoreboard;

    logic       CLK = 1'b0;
    logic       resetIn;
    logic       idValid;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       idUseRs;
    logic       idUseRt;
    logic       idRegwrite;
    logic [4:0] idDest;
    logic       idIsLoad;
    logic       flushIn;
    logic       sel5;
    logic       monEn;

    logic       stallA;
    logic [1:0] fwdA;
    logic [1:0] fwdB;
    logic [2:0] slotValidA;
    logic       retireValidA;
    logic [4:0] retireDestA;
    logic [15:0] countA;

    logic       stall5;
    logic [2:0] fwdA5;
    logic [2:0] fwdB5;
    logic [4:0] slotValid5;
    logic       retireValid5;
    logic [4:0] retireDest5;
    logic [1:0] count5;

    int checks = 0;
    int failures = 0;
    logic [4:0] expQ [$];

    always #5 CLK = ~CLK;

    pipe_scoreboard dut (
        .CLK          (CLK),
        .reset        (resetIn),
        .id_valid     (idValid & ~sel5),
        .id_rs        (idRs),
        .id_rt        (idRt),
        .id_use_rs    (idUseRs),
        .id_use_rt    (idUseRt),
        .id_regwrite  (idRegwrite),
        .id_dest      (idDest),
        .id_is_load   (idIsLoad),
        .flush        (flushIn),
        .stall        (stallA),
        .fwd_a        (fwdA),
        .fwd_b        (fwdB),
        .slot_valid   (slotValidA),
        .retire_valid (retireValidA),
        .retire_dest  (retireDestA),
        .stall_count  (countA)
    );

    pipe_scoreboard #(
        .NSTAGES    (5),
        .LOAD_READY (4),
        .SEL_W      (3),
        .CNT_W      (2)
    ) dut5 (
        .CLK          (CLK),
        .reset        (resetIn),
        .id_valid     (idValid & sel5),
        .id_rs        (idRs),
        .id_rt        (idRt),
        .id_use_rs    (idUseRs),
        .id_use_rt    (idUseRt),
        .id_regwrite  (idRegwrite),
        .id_dest      (idDest),
        .id_is_load   (idIsLoad),
        .flush        (flushIn),
        .stall        (stall5),
        .fwd_a        (fwdA5),
        .fwd_b        (fwdB5),
        .slot_valid   (slotValid5),
        .retire_valid (retireValid5),
        .retire_dest  (retireDest5),
        .stall_count  (count5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one decode instruction just after the falling edge.
    task automatic ins(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wr,
                       input logic [4:0] dest, input logic ld);
        @(negedge CLK);
        #1;
        idValid    = v;
        idRs       = rs;
        idRt       = rt;
        idUseRs    = urs;
        idUseRt    = urt;
        idRegwrite = wr;
        idDest     = dest;
        idIsLoad   = ld;
        flushIn    = 1'b0;
        #2;
    endtask

    task automatic idle();
        ins(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Record a writer the bench expects to enter slot 1 of the default instance.
    task automatic commit(input logic expStall);
        if (!sel5 && idValid && !flushIn && !resetIn && !expStall && idRegwrite &&
            (idDest != 5'd0)) begin
            expQ.push_back(idDest);
        end
    endtask

    // Retirement monitor for the default instance.
    always @(negedge CLK) begin
        if (monEn) begin
            if (retireValidA === 1'b1) begin
                check("retire_dest", retireDestA, (expQ.size() > 0) ? expQ.pop_front() : 5'd0);
            end else begin
                check("retire_dest_idle", retireDestA, 5'd0);
            end
        end
    end

    initial begin
        resetIn = 1'b1;
        sel5    = 1'b0;
        monEn   = 1'b0;
        idle();
        idle();
        check("rst_stall", stallA, 0);
        check("rst_fwd_a", fwdA, 0);
        check("rst_fwd_b", fwdB, 0);
        check("rst_slot_valid", slotValidA, 0);
        check("rst_retire_valid", retireValidA, 0);
        check("rst_count", countA, 0);
        check("rst_slot_valid5", slotValid5, 0);
        resetIn = 1'b0;
        monEn   = 1'b1;

        // ALU -> ALU forwarding from slot 1 then slot 2
        ins(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
        check("t1_add_stall", stallA, 0);
        commit(0);
        ins(1, 5'd3, 5'd4, 1, 1, 1, 5'd6, 0);
        check("t1_fwd_a1", fwdA, 1);
        check("t1_fwd_b0", fwdB, 0);
        check("t1_stall", stallA, 0);
        check("t1_slot_valid", slotValidA, 3'b001);
        commit(0);
        ins(1, 5'd3, 5'd6, 1, 1, 0, 5'd0, 0);
        check("t1_fwd_a2", fwdA, 2);
        check("t1_fwd_b1", fwdB, 1);
        check("t1_slot_valid2", slotValidA, 3'b011);
        commit(0);

        // Load-use on rt: one stall cycle, then forward from slot 2
        ins(1, 5'd0, 5'd0, 1, 0, 1, 5'd5, 1);
        check("t2_lw_stall", stallA, 0);
        check("t2_lw_fwd_a", fwdA, 0);
        commit(0);
        ins(1, 5'd7, 5'd5, 1, 1, 1, 5'd8, 0);
        check("t2_stall", stallA, 1);
        check("t2_count0", countA, 0);
        commit(1);
        ins(1, 5'd7, 5'd5, 1, 1, 1, 5'd8, 0);
        check("t2_stall_end", stallA, 0);
        check("t2_fwd_b2", fwdB, 2);
        check("t2_fwd_a0", fwdA, 0);
        check("t2_bubble", slotValidA, 3'b010);
        check("t2_count1", countA, 1);
        commit(0);

        // Two producers of r4: youngest wins
        ins(1, 5'd0, 5'd0, 0, 0, 1, 5'd4, 0);
        commit(0);
        ins(1, 5'd1, 5'd2, 1, 1, 1, 5'd4, 0);
        commit(0);
        ins(1, 5'd4, 5'd4, 1, 1, 0, 5'd0, 0);
        check("t3_fwd_a", fwdA, 1);
        check("t3_fwd_b", fwdB, 1);
        check("t3_stall", stallA, 0);
        commit(0);

        // Writes to r0 are never tracked
        ins(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 0);
        commit(0);
        ins(1, 5'd0, 5'd0, 1, 1, 1, 5'd9, 0);
        check("t4_fwd_a", fwdA, 0);
        check("t4_fwd_b", fwdB, 0);
        check("t4_stall", stallA, 0);
        check("t4_slot1", slotValidA[0], 0);
        commit(0);

        // Load-use hazard coinciding with flush
        ins(1, 5'd1, 5'd1, 1, 1, 1, 5'd10, 1);
        commit(0);
        ins(1, 5'd10, 5'd0, 1, 0, 1, 5'd12, 0);
        flushIn = 1'b1;
        #1;
        check("t5_flush_stall", stallA, 0);
        commit(0);
        idle();
        check("t5_flush_bubble", slotValidA[0], 0);
        check("t5_flush_count", countA, 1);

        // Reset asserted during a stall cycle
        ins(1, 5'd1, 5'd1, 1, 1, 1, 5'd11, 1);
        commit(0);
        ins(1, 5'd11, 5'd0, 1, 0, 1, 5'd13, 0);
        resetIn = 1'b1;
        expQ.delete();
        #1;
        check("t5_pre_reset_stall", stallA, 1);
        commit(1);
        ins(1, 5'd11, 5'd0, 1, 0, 1, 5'd13, 0);
        resetIn = 1'b0;
        check("t5_rst_slot_valid", slotValidA, 0);
        check("t5_rst_stall", stallA, 0);
        check("t5_rst_count", countA, 0);
        check("t5_rst_retire", retireValidA, 0);
        commit(0);

        repeat (4) idle();
        check("queue_drained", expQ.size(), 0);

        // Deep instance: three-cycle load-use stall and counter saturation
        sel5 = 1'b1;
        ins(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 1);
        check("t6_lw_stall", stall5, 0);
        for (int i = 0; i < 3; i++) begin
            ins(1, 5'd7, 5'd0, 1, 0, 0, 5'd0, 0);
            check("t6_stall", stall5, 1);
            check("t6_count", count5, i);
        end
        ins(1, 5'd7, 5'd0, 1, 0, 0, 5'd0, 0);
        check("t6_stall_end", stall5, 0);
        check("t6_fwd_a4", fwdA5, 4);
        check("t6_slot_valid", slotValid5, 5'b01000);
        check("t6_count3", count5, 3);
        ins(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 1);
        for (int i = 0; i < 3; i++) begin
            ins(1, 5'd7, 5'd0, 1, 0, 0, 5'd0, 0);
            check("t6_sat_stall", stall5, 1);
            check("t6_sat_count", count5, 3);
        end
        ins(1, 5'd7, 5'd0, 1, 0, 0, 5'd0, 0);
        check("t6_sat_final", count5, 3);
        check("t6_fwd_a4b", fwdA5, 4);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
